page_qin_rr_arbiter: RTL and testbench
======================================

# page_qin_rr_arbiter

Round-robin arbiter that shares one page input queue stream between `NIN` producer streams using the codebase's stream convention: data `_d`, end-of-stream flag `_e`, valid `_v`, and back-pressure `_b`. It sits in front of a page `_qin` queue instance and drives that queue's `qin` side. Its job is to merge token streams fairly, optionally lock a grant until end-of-stream, and coalesce per-producer end-of-stream tokens into one.

## Interface
Parameters:
- `WIDTH`, default 16: data token width.
- `NIN`, default 2: number of producer streams; legal range 2..8.
- `LOCK`, default 0: when 1, a grant is held on one producer until that producer's eos token.
- `MERGE_EOS`, default 1: when 1, per-input eos tokens are swallowed and a single eos is emitted after all inputs finish.

Ports:
- `clock`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high.
- `in_d`, input, `NIN*WIDTH`: packed producer data; input i occupies `[i*WIDTH +: WIDTH]`.
- `in_e`, input, `NIN`: per-input eos flag.
- `in_v`, input, `NIN`: per-input valid.
- `in_b`, output, `NIN`: per-input back-pressure; 1 means stall.
- `out_d`, output, `WIDTH`: merged data to the queue `qin_d`.
- `out_e`, output, 1: merged eos flag.
- `out_v`, output, 1: merged valid.
- `out_b`, input, 1: back-pressure from the queue.

## Operation
- Transfer rule: a token moves on a port in any cycle where `v=1` and `b=0`. An eos token has `e=1`; its data is don't-care.
- Output stage: a single register holds `out_d`, `out_e` and `out_v`.
  - `accept = (state==RUN) && (!out_v || !out_b)`.
  - On a granted transfer, the register loads the token. Otherwise, if `out_v && !out_b`, the register clears `out_v`.
- Eligible set: `in_v[i] && !done[i]`.
- Grant, combinational: the first eligible input found scanning upward from `ptr` and wrapping around. With `LOCK=1` and `lock_valid` set, only `lock_id` may be granted.
- Back-pressure: `in_b[i] = !(grant[i] && accept)`.
  - Every non-granted input sees `in_b=1`.
  - `in_b[i]` depends combinationally on `in_v`, `out_b` and state.
- Pointer: after each transfer from input g, `ptr <= (g+1) mod NIN`.
- Lock (`LOCK=1`):
  - A non-eos transfer from g sets `lock_valid=1` and `lock_id=g`.
  - An eos transfer from the locked input clears `lock_valid`.
- eos handling:
  - An eos transfer from input i sets `done[i]`. Input i is never granted again until reset.
  - With `MERGE_EOS=0`, every eos token is forwarded.
  - With `MERGE_EOS=1`, eos tokens are absorbed and never loaded into the output register. When the absorbed eos makes all `done` bits set, the state goes to FLUSH.
- States (2-bit):
  - RUN: normal arbitration. Goes to FLUSH when all inputs are done and `MERGE_EOS=1`. Goes to DONE when all inputs are done and `MERGE_EOS=0`.
  - FLUSH: no grants are issued. When `!out_v || !out_b`, load `{d=0, e=1, v=1}` and go to DONE.
  - DONE: all `in_b=1`. The output register drains normally. The block stays in DONE until reset.
- Reset values:
  - `out_v=0`, `out_e=0`, `out_d=0`.
  - `in_b` all 1 while reset is asserted.
  - `ptr=0`, `done=0`, `lock_valid=0`, state RUN.
- Reset mid-stream discards a held output token; no partial state survives.

## Timing
- Latency: input transfer at cycle t gives `out_v=1` with that token at t+1.
- Throughput: 1 token per cycle while `out_b=0`.
- When `out_b=1` with `out_v=1`: `accept=0`, so all `in_b=1`, and the held token is stable until taken.
- Simultaneous drain and load: if `out_b=0` and a grant occurs in the same cycle, the new token replaces the old one with no bubble.
- FLUSH emits its eos no earlier than 1 cycle after the last absorbed eos. It waits for the held data token to drain first, so all data precedes the merged eos.
- Last-input eos with `MERGE_EOS=1`: the output register is not loaded that cycle. Any data still held drains normally.

## Structure
- Shared package `page_stream_pkg` holds:
  - the state encoding (RUN=0, FLUSH=1, DONE=2);
  - the helper `rr_next(ptr, NIN)`;
  - the stream-token field layout `{d, e}`, used the same way by queue instances.
- One sub-module, `rr_grant`: a parameterized `NIN`-way round-robin priority encoder.
  - Inputs: `req[NIN-1:0]`, `ptr`.
  - Outputs: one-hot `gnt`, encoded `gnt_id`, `any`.
- Everything else lives in the top module.

## Test plan
- Fairness: `NIN=2`, both inputs continuously valid, `out_b=0`, `LOCK=0` → output alternates 0,1,0,1…, one token per cycle, the first token appears at cycle 1 after the first grant.
- Back-pressure: hold `out_b=1` for 3 cycles with `out_v=1` → `out_d` is stable, all `in_b=1`, no token is lost or duplicated; release → the stream resumes next cycle.
- Lock: `LOCK=1`, input0 sends 0x0A, 0x0B, eos while input1 is valid throughout → output 0x0A, 0x0B, then input1's tokens; input1 is never granted before input0's eos.
- Merged eos: `MERGE_EOS=1`, input0 eos at cycle 5, input1 data 0x33 then eos at cycle 8 → output carries 0x33, then exactly one token with `e=1`, `d=0`; state reaches DONE and `in_b` stays all 1.
- Forwarded eos: `MERGE_EOS=0`, both inputs send eos → two `e=1` tokens appear in arbitration order, then DONE.
- Reset mid-stream: assert `reset` while `out_v=1` and a lock is held → next cycle `out_v=0` and `in_b` all 1; after deassert, arbitration restarts at input 0 with all `done` bits cleared.

Source files
------------

// File: rtl/page_stream_pkg.sv
// Shared stream definitions for page queue front-ends: state encoding, pointer helper, token layout.
// A stream token is packed as {d, e}, so the eos flag sits at bit TOK_E_BIT and data occupies the bits above it.
package page_stream_pkg;

    localparam int PTR_W     = 3;
    localparam int TOK_E_BIT = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int nin);
        if (int'(ptr) >= nin - 1) return '0;
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// NIN-way round-robin priority encoder: first set request at or above ptr, wrapping to index 0.
// Purely combinational; one-hot gnt, encoded gnt_id and an any-request flag.
module rr_grant
    import page_stream_pkg::*;
#(
    parameter int NIN = 2
) (
    input  logic [NIN-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NIN-1:0]   gnt,
    output logic [PTR_W-1:0] gnt_id,
    output logic             any
);

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        // First pass covers ptr..NIN-1, second pass wraps around from 0.
        for (int i = 0; i < NIN; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = PTR_W'(i);
            end
        end
        for (int i = 0; i < NIN; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/page_qin_rr_arbiter.sv
// Merges NIN producer streams into one page queue input with round-robin fairness, optional grant lock and eos coalescing.
// One register stage (1-cycle latency, full throughput); out_b with a held token stalls every producer via in_b.
module page_qin_rr_arbiter
    import page_stream_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NIN       = 2,
    parameter int LOCK      = 0,
    parameter int MERGE_EOS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NIN*WIDTH-1:0] in_d,
    input  logic [NIN-1:0]       in_e,
    input  logic [NIN-1:0]       in_v,
    output logic [NIN-1:0]       in_b,
    output logic [WIDTH-1:0]     out_d,
    output logic                 out_e,
    output logic                 out_v,
    input  logic                 out_b
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NIN-1:0]   done_q, done_d;
    logic             lock_valid_q, lock_valid_d;
    logic [PTR_W-1:0] lock_id_q, lock_id_d;
    logic [WIDTH:0]   obuf_q, obuf_d;
    logic             ovld_q, ovld_d;

    logic [NIN-1:0]   req, gnt, lock_mask;
    logic [PTR_W-1:0] gnt_id;
    logic             any, accept, xfer, sel_e;
    logic [WIDTH-1:0] sel_d;

    always_comb begin
        for (int i = 0; i < NIN; i++) lock_mask[i] = (lock_id_q == PTR_W'(i));
        req = in_v & ~done_q;
        if ((LOCK != 0) && lock_valid_q) req = req & lock_mask;
    end

    rr_grant #(.NIN(NIN)) u_rr_grant (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_comb begin
        sel_d = '0;
        for (int i = 0; i < NIN; i++) begin
            if (gnt[i]) sel_d = in_d[i*WIDTH +: WIDTH];
        end
        sel_e = |(in_e & gnt);
    end

    assign accept = (state_q == ST_RUN) && (!ovld_q || !out_b);
    assign xfer   = any && accept;
    assign in_b   = reset ? '1 : ~(gnt & {NIN{accept}});

    assign out_d  = obuf_q[WIDTH:1];
    assign out_e  = obuf_q[TOK_E_BIT];
    assign out_v  = ovld_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        done_d       = done_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        obuf_d       = obuf_q;
        ovld_d       = ovld_q;
        if (ovld_q && !out_b) ovld_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (xfer) begin
                    ptr_d = rr_next(gnt_id, NIN);
                    if (sel_e) done_d = done_q | gnt;
                    if (LOCK != 0) begin
                        if (!sel_e) begin
                            lock_valid_d = 1'b1;
                            lock_id_d    = gnt_id;
                        end else if (lock_valid_q && (lock_id_q == gnt_id)) begin
                            lock_valid_d = 1'b0;
                        end
                    end
                    // Absorbed eos tokens never reach the output register.
                    if (!(sel_e && (MERGE_EOS != 0))) begin
                        obuf_d = {sel_d, sel_e};
                        ovld_d = 1'b1;
                    end
                    if (&done_d) state_d = (MERGE_EOS != 0) ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (!ovld_q || !out_b) begin
                    obuf_d  = {WIDTH'(0), 1'b1};
                    ovld_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            ptr_q        <= '0;
            done_q       <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            obuf_q       <= '0;
            ovld_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            done_q       <= done_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            obuf_q       <= obuf_d;
            ovld_q       <= ovld_d;
        end
    end

endmodule

// File: tb/tb_page_qin_rr_arbiter.sv
// Scoreboard bench: three arbiter configurations share stimulus; a monitor checks the selected one's output stream.
module tb_page_qin_rr_arbiter;

    localparam int W = 16;
    localparam int N = 2;
    localparam logic [W:0] EOS = {16'h0000, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N*W-1:0] in_d;
    logic [N-1:0]   in_e, in_v;
    logic           out_b;

    logic [N-1:0] b_a, b_b, b_c;
    logic [W-1:0] d_a, d_b, d_c;
    logic         e_a, e_b, e_c, v_a, v_b, v_c;

    page_qin_rr_arbiter #(.WIDTH(W), .NIN(N), .LOCK(0), .MERGE_EOS(1)) u_a (
        .clock(clk), .reset(reset), .in_d(in_d), .in_e(in_e), .in_v(in_v), .in_b(b_a),
        .out_d(d_a), .out_e(e_a), .out_v(v_a), .out_b(out_b));
    page_qin_rr_arbiter #(.WIDTH(W), .NIN(N), .LOCK(1), .MERGE_EOS(1)) u_b (
        .clock(clk), .reset(reset), .in_d(in_d), .in_e(in_e), .in_v(in_v), .in_b(b_b),
        .out_d(d_b), .out_e(e_b), .out_v(v_b), .out_b(out_b));
    page_qin_rr_arbiter #(.WIDTH(W), .NIN(N), .LOCK(0), .MERGE_EOS(0)) u_c (
        .clock(clk), .reset(reset), .in_d(in_d), .in_e(in_e), .in_v(in_v), .in_b(b_c),
        .out_d(d_c), .out_e(e_c), .out_v(v_c), .out_b(out_b));

    int           sel;
    logic [N-1:0] in_b;
    logic [W-1:0] out_d;
    logic         out_e, out_v;

    always_comb begin
        case (sel)
            0:       begin in_b = b_a; out_d = d_a; out_e = e_a; out_v = v_a; end
            1:       begin in_b = b_b; out_d = d_b; out_e = e_b; out_v = v_b; end
            default: begin in_b = b_c; out_d = d_c; out_e = e_c; out_v = v_c; end
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] src0[$];
    logic [W:0] src1[$];
    logic [W:0] exp_q[$];
    logic en;
    logic [W-1:0] held;

    function automatic logic [W:0] dt(input logic [W-1:0] d);
        return {d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive();
        in_v = '0; in_e = '0; in_d = '0;
        if (src0.size() > 0) begin
            in_v[0] = en; in_d[W-1:0] = src0[0][W:1]; in_e[0] = src0[0][0];
        end
        if (src1.size() > 0) begin
            in_v[1] = en; in_d[2*W-1:W] = src1[0][W:1]; in_e[1] = src1[0][0];
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int s);
        sel = s; reset = 1'b1; en = 1'b0; out_b = 1'b0;
        src0.delete(); src1.delete(); exp_q.delete();
        drive();
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            step(1);
            t++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        step(5);
    endtask

    // Producers: a token leaves its source queue on each cycle where v=1 and b=0.
    initial begin
        logic f0, f1;
        forever begin
            @(negedge clk);
            f0 = in_v[0] && !in_b[0] && !reset;
            f1 = in_v[1] && !in_b[1] && !reset;
            @(posedge clk);
            #1;
            if (f0 && src0.size() > 0) void'(src0.pop_front());
            if (f1 && src1.size() > 0) void'(src1.pop_front());
            drive();
        end
    end

    // Monitor: every output transfer is checked against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_v && !out_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_token: got d=%h e=%b expected none", out_d, out_e);
                end else begin
                    logic [W:0] x;
                    x = exp_q.pop_front();
                    if ({out_d, out_e} !== x) begin
                        n_err++;
                        $display("FAIL token: got d=%h e=%b expected d=%h e=%b", out_d, out_e, x[W:1], x[0]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; sel = 0; en = 1'b1; out_b = 1'b0;
        src0.push_back(dt(16'h0001)); src1.push_back(dt(16'h0002));
        drive();
        step(2);
        @(negedge clk);
        chk("rst_in_b", in_b, 2'b11);
        chk("rst_out_v_a", v_a, 0);
        chk("rst_out_v_b", v_b, 0);
        chk("rst_out_v_c", v_c, 0);
        chk("rst_out_e", out_e, 0);
        chk("rst_out_d", out_d, 0);

        // Fairness and back-pressure
        do_reset(0);
        for (int k = 0; k < 6; k++) begin
            src0.push_back(dt(16'(16'h100 + k)));
            src1.push_back(dt(16'(16'h200 + k)));
            exp_q.push_back(dt(16'(16'h100 + k)));
            exp_q.push_back(dt(16'(16'h200 + k)));
        end
        en = 1'b1;
        drive();
        @(negedge clk);
        chk("first_idle", out_v, 0);
        @(negedge clk);
        chk("first_vld", out_v, 1);
        chk("first_d", out_d, 16'h100);
        @(negedge clk);
        chk("tput_1", out_v, 1);
        @(negedge clk);
        chk("tput_2", out_v, 1);
        step(1);
        out_b = 1'b1;
        @(negedge clk);
        held = out_d;
        chk("bp_vld", out_v, 1);
        chk("bp_in_b0", in_b, 2'b11);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stable", out_d, held);
            chk("bp_in_b", in_b, 2'b11);
        end
        step(1);
        out_b = 1'b0;
        @(negedge clk);
        chk("bp_resume_v", out_v, 1);
        chk("bp_resume_d", out_d, held);
        wait_drain("fair");

        // Merged eos: input0 data queued behind its eos must never be granted
        do_reset(0);
        src0.push_back(EOS); src0.push_back(dt(16'h0099));
        src1.push_back(dt(16'h0033)); src1.push_back(EOS);
        exp_q.push_back(dt(16'h0033)); exp_q.push_back(EOS);
        en = 1'b1;
        drive();
        wait_drain("merge");
        @(negedge clk);
        chk("merge_done_in_b", in_b, 2'b11);
        chk("merge_src0_left", src0.size(), 1);

        // Lock held on input0 until its eos
        do_reset(1);
        src0.push_back(dt(16'h000A)); src0.push_back(dt(16'h000B)); src0.push_back(EOS);
        src1.push_back(dt(16'h0021)); src1.push_back(dt(16'h0022)); src1.push_back(dt(16'h0023));
        src1.push_back(EOS);
        exp_q.push_back(dt(16'h000A)); exp_q.push_back(dt(16'h000B));
        exp_q.push_back(dt(16'h0021)); exp_q.push_back(dt(16'h0022)); exp_q.push_back(dt(16'h0023));
        exp_q.push_back(EOS);
        en = 1'b1;
        drive();
        wait_drain("lock");

        // Forwarded eos
        do_reset(2);
        src0.push_back(EOS); src0.push_back(dt(16'h0055));
        src1.push_back(EOS);
        exp_q.push_back(EOS); exp_q.push_back(EOS);
        en = 1'b1;
        drive();
        wait_drain("fwd");
        @(negedge clk);
        chk("fwd_done_in_b", in_b, 2'b11);
        chk("fwd_src0_left", src0.size(), 1);

        // Reset mid-stream with a lock held and a token parked in the output register
        do_reset(1);
        out_b = 1'b1;
        src0.push_back(dt(16'h0041)); src0.push_back(dt(16'h0042));
        src1.push_back(dt(16'h0051));
        en = 1'b1;
        drive();
        step(2);
        @(negedge clk);
        chk("mid_held_v", out_v, 1);
        chk("mid_held_d", out_d, 16'h0041);
        step(1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_b", in_b, 2'b11);
        @(negedge clk);
        chk("mid_rst_out_v", out_v, 0);
        step(1);
        reset = 1'b0;
        out_b = 1'b0;
        src0.delete(); src1.delete();
        src0.push_back(dt(16'h0061)); src0.push_back(EOS);
        src1.push_back(dt(16'h0071)); src1.push_back(EOS);
        exp_q.push_back(dt(16'h0061)); exp_q.push_back(dt(16'h0071)); exp_q.push_back(EOS);
        drive();
        wait_drain("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
